// File: rtl/key_pulse_conditioner_if.sv
// Button-side bundle of the key pulse conditioner: raw button levels in,
// one-cycle press pulses and the key-held flag out.
interface key_pulse_conditioner_if;
    logic btn_a;
    logic btn_b;
    logic btn_c;
    logic a;
    logic b;
    logic c;
    logic key_held;

    modport master (
        output btn_a, btn_b, btn_c,
        input  a, b, c, key_held
    );

    modport slave (
        input  btn_a, btn_b, btn_c,
        output a, b, c, key_held
    );
endinterface

// File: rtl/key_pulse_conditioner.sv
// Turns three raw bouncing push-buttons into clean one-cycle press pulses,
// one key at a time, ignoring keys already held when reset is released.
module key_pulse_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter bit          ACTIVE_LOW_BTN  = 1'b0
) (
    input logic clk,
    input logic rst_n,
    key_pulse_conditioner_if.slave bus
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] QUIET_FULL = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        HELD = 2'd2
    } state_t;

    logic [2:0] raw_level;
    logic [2:0] synced;
    logic [2:0] db_level;
    logic [2:0] db_d_reg;
    logic [2:0] press_reg;
    logic [CW-1:0] quiet_reg;
    state_t state_reg;
    logic [2:0] pulse_reg;
    logic held_reg;

    // Index 0 = A, 1 = B, 2 = C throughout; 1 means pressed after this point.
    assign raw_level = ACTIVE_LOW_BTN ? ~{bus.btn_c, bus.btn_b, bus.btn_a}
                                      :  {bus.btn_c, bus.btn_b, bus.btn_a};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CW-1:0] cnt_reg;
            logic db_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                    cnt_reg  <= '0;
                    db_reg   <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_level[gi]};
                    if (sync_reg[SYNC_STAGES-1] == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        cnt_reg <= '0;
                        db_reg  <= sync_reg[SYNC_STAGES-1];
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
            end

            assign synced[gi]   = sync_reg[SYNC_STAGES-1];
            assign db_level[gi] = db_reg;
        end
    endgenerate

    // Press detection and the quiet counter that releases the ARM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_d_reg  <= '0;
            press_reg <= '0;
            quiet_reg <= '0;
        end else begin
            db_d_reg  <= db_level;
            press_reg <= db_level & ~db_d_reg;
            if (|synced) begin
                quiet_reg <= '0;
            end else if (quiet_reg != QUIET_FULL) begin
                quiet_reg <= quiet_reg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ARM;
            pulse_reg <= '0;
            held_reg  <= 1'b1;
        end else begin
            pulse_reg <= '0;
            case (state_reg)
                ARM: begin
                    if (quiet_reg == QUIET_FULL) begin
                        state_reg <= IDLE;
                        held_reg  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (|press_reg) begin
                        state_reg <= HELD;
                        held_reg  <= 1'b1;
                        // Fixed priority A > B > C; losers are simply dropped.
                        if (press_reg[0]) begin
                            pulse_reg <= 3'b001;
                        end else if (press_reg[1]) begin
                            pulse_reg <= 3'b010;
                        end else begin
                            pulse_reg <= 3'b100;
                        end
                    end
                end
                HELD: begin
                    if (db_d_reg == 3'b000) begin
                        state_reg <= IDLE;
                        held_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ARM;
                    held_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.a        = pulse_reg[0];
    assign bus.b        = pulse_reg[1];
    assign bus.c        = pulse_reg[2];
    assign bus.key_held = held_reg;
endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Bench for key_pulse_conditioner: directed keypress scenarios plus random
// bouncing stimulus, all checked every cycle against a behavioural model.
module tb_key_pulse_conditioner;
    localparam int D = 4;
    localparam int S = 2;
    localparam int N = S + D + 1;

    typedef enum int {M_ARM, M_IDLE, M_HELD} mstate_t;

    logic clk = 1'b0;
    logic rst_n;
    key_pulse_conditioner_if kif();

    key_pulse_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES(S),
        .ACTIVE_LOW_BTN(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(kif)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int edge_cnt = 0;
    int pulse_cnt[3] = '{0, 0, 0};
    int pulse_edge[3] = '{-1, -1, -1};
    bit model_valid = 1'b0;

    // Behavioural model: raw history -> synchroniser delay -> window debounce.
    mstate_t    m_state;
    logic [2:0] sync_q[$];
    logic [2:0] win_q[$];
    logic [2:0] db_m, vis_m, press_m, exp_pulse;
    logic       exp_held;

    task automatic model_reset();
        m_state = M_ARM;
        sync_q.delete();
        for (int i = 0; i < S; i++) sync_q.push_back(3'b000);
        win_q.delete();
        db_m = '0; vis_m = '0; press_m = '0;
        exp_pulse = '0; exp_held = 1'b1;
        model_valid = 1'b1;
    endtask

    task automatic model_step();
        logic [2:0] raw, sy_old, db_old, vis_old, press_old;
        bit quiet, flip;
        edge_cnt++;
        raw = {kif.btn_c, kif.btn_b, kif.btn_a};
        sy_old = sync_q[S-1];
        db_old = db_m; vis_old = vis_m; press_old = press_m;
        quiet = (win_q.size() == D);
        foreach (win_q[i]) if (win_q[i] != 3'b000) quiet = 1'b0;
        exp_pulse = '0;
        case (m_state)
            M_ARM: if (quiet) begin m_state = M_IDLE; exp_held = 1'b0; end
            M_IDLE: if (press_old != 3'b000) begin
                m_state = M_HELD; exp_held = 1'b1;
                if (press_old[0]) exp_pulse = 3'b001;
                else if (press_old[1]) exp_pulse = 3'b010;
                else exp_pulse = 3'b100;
            end
            M_HELD: if (vis_old == 3'b000) begin m_state = M_IDLE; exp_held = 1'b0; end
            default: m_state = M_ARM;
        endcase
        press_m = db_old & ~vis_old;
        vis_m = db_old;
        win_q.push_back(sy_old);
        if (win_q.size() > D) void'(win_q.pop_front());
        for (int k = 0; k < 3; k++) begin
            flip = (win_q.size() == D);
            foreach (win_q[i]) if (win_q[i][k] == db_old[k]) flip = 1'b0;
            if (flip) db_m[k] = ~db_old[k];
        end
        sync_q.push_front(raw);
        void'(sync_q.pop_back());
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            logic [2:0] got;
            got = {kif.c, kif.b, kif.a};
            vectors++;
            if (got !== exp_pulse || kif.key_held !== exp_held) begin
                miscompares++;
                $display("FAIL cycle_check edge=%0d got pulses(cba)=%b held=%b required pulses=%b held=%b",
                         edge_cnt, got, kif.key_held, exp_pulse, exp_held);
            end
            for (int k = 0; k < 3; k++) begin
                if (got[k] === 1'b1) begin
                    pulse_cnt[k]++;
                    pulse_edge[k] = edge_cnt;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    initial begin
        int p0, pc, re, rl;
        int rem[3];
        logic lvl[3];
        rst_n = 1'b0;
        kif.btn_a = 1'b0; kif.btn_b = 1'b0; kif.btn_c = 1'b0;

        // 1: reset with keys released
        wait_cyc(3);
        check("reset_held", kif.key_held, 1);
        check("reset_pulses", {kif.c, kif.b, kif.a}, 0);
        rst_n = 1'b1;
        wait_cyc(N);
        check("arm_exit_held", kif.key_held, 0);
        check("arm_no_pulses", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 0);

        // 2: single A press with release latency
        p0 = pulse_cnt[0];
        kif.btn_a = 1'b1; re = edge_cnt + 1;
        wait_cyc(20);
        check("a_count", pulse_cnt[0] - p0, 1);
        check("a_latency", pulse_edge[0] - re, N);
        kif.btn_a = 1'b0; rl = edge_cnt + 1;
        wait_cyc(N);
        check("a_held_before_release", kif.key_held, 1);
        wait_cyc(1);
        check("a_release_latency", kif.key_held, 0);
        wait_cyc(5);

        // 3: bouncing B then stable
        p0 = pulse_cnt[1];
        for (int i = 0; i < 12; i++) begin
            kif.btn_b = ((i / 2) % 2 == 0);
            wait_cyc(1);
        end
        kif.btn_b = 1'b1; re = edge_cnt + 1;
        wait_cyc(15);
        check("b_bounce_count", pulse_cnt[1] - p0, 1);
        check("b_bounce_latency", pulse_edge[1] - re, N);
        kif.btn_b = 1'b0;
        wait_cyc(12);

        // 4: A and C together
        p0 = pulse_cnt[0]; pc = pulse_cnt[2];
        kif.btn_a = 1'b1; kif.btn_c = 1'b1; re = edge_cnt + 1;
        wait_cyc(15);
        check("ac_a_count", pulse_cnt[0] - p0, 1);
        check("ac_a_latency", pulse_edge[0] - re, N);
        kif.btn_a = 1'b0;
        wait_cyc(12);
        check("ac_held_c_still_down", kif.key_held, 1);
        kif.btn_c = 1'b0;
        wait_cyc(12);
        check("ac_idle", kif.key_held, 0);
        check("ac_no_c", pulse_cnt[2] - pc, 0);

        // 5: C pressed under B, B released first
        p0 = pulse_cnt[1]; pc = pulse_cnt[2];
        kif.btn_b = 1'b1; wait_cyc(12);
        kif.btn_c = 1'b1; wait_cyc(10);
        kif.btn_b = 1'b0; wait_cyc(15);
        check("bc_b_count", pulse_cnt[1] - p0, 1);
        check("bc_no_c", pulse_cnt[2] - pc, 0);
        check("bc_held", kif.key_held, 1);
        kif.btn_c = 1'b0; wait_cyc(12);
        kif.btn_c = 1'b1; re = edge_cnt + 1; wait_cyc(12);
        check("bc_c_repress", pulse_cnt[2] - pc, 1);
        check("bc_c_latency", pulse_edge[2] - re, N);
        kif.btn_c = 1'b0; wait_cyc(12);

        // 6: reset while C held
        kif.btn_c = 1'b1; wait_cyc(12);
        pc = pulse_cnt[2];
        rst_n = 1'b0;
        #1;
        check("rst_async_pulses", {kif.c, kif.b, kif.a}, 0);
        check("rst_async_held", kif.key_held, 1);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(20);
        check("rst_hold_no_c", pulse_cnt[2] - pc, 0);
        check("rst_hold_held", kif.key_held, 1);
        kif.btn_c = 1'b0; wait_cyc(6);
        kif.btn_c = 1'b1; wait_cyc(12);
        check("rst_c_after_rearm", pulse_cnt[2] - pc, 1);
        kif.btn_c = 1'b0; wait_cyc(12);

        // Random bouncing stimulus
        for (int k = 0; k < 3; k++) begin rem[k] = 0; lvl[k] = 1'b0; end
        for (int t = 0; t < 3000; t++) begin
            for (int k = 0; k < 3; k++) begin
                if (rem[k] == 0) begin
                    lvl[k] = ~lvl[k];
                    rem[k] = $urandom_range(1, 12);
                end else begin
                    rem[k]--;
                end
            end
            kif.btn_a = lvl[0]; kif.btn_b = lvl[1]; kif.btn_c = lvl[2];
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                wait_cyc(2);
                rst_n = 1'b1;
            end
            wait_cyc(1);
        end
        kif.btn_a = 1'b0; kif.btn_b = 1'b0; kif.btn_c = 1'b0;
        wait_cyc(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
